// File: rtl/spi_loader.sv
// spi_loader: serial frame deserialiser feeding the icache/dcache write ports.
// Frame = {cmd, addr[ADDR_W-1:0], data[DATA_W-1:0]}, MSB first, one bit per clk.
// Optional dcache readback on miso is built only when SPI_LOADER_READBACK_EN is defined.
module spi_loader #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DMEM_SZ = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              csi_in,
  input  logic              csd_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic              icache_wen_out,
  output logic              dcache_wen_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [DATA_W-1:0] wr_data_out,
  output logic [ADDR_W-1:0] rd_addr_out,
  input  logic [DATA_W-1:0] rd_data_in,
  output logic              loading_out,
  output logic              err_out
);

  localparam int unsigned LastBit = ADDR_W + DATA_W;
  localparam int unsigned CntW    = $clog2(LastBit + 1);

  localparam logic [CntW-1:0]   CntAddrLast  = CntW'(ADDR_W);
  localparam logic [CntW-1:0]   CntFirstData = CntW'(ADDR_W + 1);
  localparam logic [CntW-1:0]   CntLast      = CntW'(LastBit);
  localparam logic [ADDR_W:0]   DmemSz       = (ADDR_W + 1)'(DMEM_SZ);

  typedef enum logic [1:0] {StIdle, StCmd, StAddr, StData} state_t;

  state_t            r_state;
  logic [CntW-1:0]   r_cnt;
  logic              r_cmd;
  logic              r_tgt_d;  // latched target: 1 = dcache, 0 = icache
  logic [DATA_W-2:0] r_data;   // data bits before the last one

  logic              w_sel_one;
  logic              w_sel_both;
  logic              w_sel_own;
  logic [ADDR_W-1:0] w_addr_full;
  logic              w_addr_ok;

  assign w_sel_one   = csi_in ^ csd_in;
  assign w_sel_both  = csi_in & csd_in;
  // The frame's own select alone; anything else mid-frame is an abort.
  assign w_sel_own   = r_tgt_d ? (csd_in & ~csi_in) : (csi_in & ~csd_in);
  assign w_addr_full = {rd_addr_out[ADDR_W-2:0], mosi_in};
  // rd_addr_out holds the complete frame address from the first data bit on.
  assign w_addr_ok   = {1'b0, rd_addr_out} < DmemSz;

  assign loading_out = csi_in | csd_in | (r_state != StIdle) | icache_wen_out | dcache_wen_out;

`ifdef SPI_LOADER_READBACK_EN
  logic [DATA_W-2:0] r_out_sh;
  logic              w_full_ok;
  logic              w_rd_active;

  assign w_full_ok   = {1'b0, w_addr_full} < DmemSz;
  assign w_rd_active = (r_state == StData) && !r_cmd && r_tgt_d && w_addr_ok;

  // First readback bit comes straight from the cache; the rest from the shift register.
  always_comb begin
    miso_out = 1'b0;
    if (w_rd_active) begin
      miso_out = (r_cnt == CntFirstData) ? rd_data_in[DATA_W-1] : r_out_sh[DATA_W-2];
    end
  end

  // Out-shift register: capture on the first data cycle, then shift toward the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_sh <= '0;
    end else if (r_state == StData) begin
      if (r_cnt == CntFirstData) begin
        r_out_sh <= rd_data_in[DATA_W-2:0];
      end else begin
        r_out_sh <= {r_out_sh[DATA_W-3:0], 1'b0};
      end
    end
  end
`else
  logic w_unused_rd;
  assign w_unused_rd = ^rd_data_in;
  assign miso_out    = 1'b0;
`endif

  // Frame FSM: bit counter, shift-in, abort detection and registered write strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_cmd          <= 1'b0;
      r_tgt_d        <= 1'b0;
      r_data         <= '0;
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      rd_addr_out    <= '0;
      err_out        <= 1'b0;
    end else begin
      icache_wen_out <= 1'b0;
      dcache_wen_out <= 1'b0;
      unique case (r_state)
        StIdle, StCmd: begin
          if (w_sel_one && (r_state == StIdle || w_sel_own)) begin
            r_cmd   <= mosi_in;
            r_tgt_d <= csd_in;
            r_cnt   <= CntW'(1);
            r_state <= StAddr;
          end else begin
            r_cnt   <= '0;
            r_state <= StIdle;
            // Both selects, or a switch of select between back-to-back frames.
            if (w_sel_both || (r_state == StCmd && w_sel_one)) begin
              err_out <= 1'b1;
            end
          end
        end
        StAddr: begin
          if (!w_sel_own) begin
            r_cnt   <= '0;
            r_state <= StIdle;
            err_out <= 1'b1;
          end else begin
            rd_addr_out <= w_addr_full;
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt == CntAddrLast) begin
              r_state <= StData;
`ifdef SPI_LOADER_READBACK_EN
              if (!r_cmd && r_tgt_d && !w_full_ok) begin
                err_out <= 1'b1;
              end
`endif
            end
          end
        end
        StData: begin
          if (!w_sel_own) begin
            r_cnt   <= '0;
            r_state <= StIdle;
            err_out <= 1'b1;
          end else if (r_cnt == CntLast) begin
            r_cnt   <= '0;
            r_state <= StCmd;
            if (r_cmd) begin
              if (!r_tgt_d || w_addr_ok) begin
                icache_wen_out <= ~r_tgt_d;
                dcache_wen_out <= r_tgt_d;
                wr_addr_out    <= rd_addr_out;
                wr_data_out    <= {r_data, mosi_in};
              end else begin
                err_out <= 1'b1;
              end
            end
          end else begin
            r_data <= {r_data[DATA_W-3:0], mosi_in};
            r_cnt  <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_loader.sv
// Directed bench for spi_loader; readback expectations follow SPI_LOADER_READBACK_EN.
module tb_spi_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       csi_in = 1'b0;
  logic       csd_in = 1'b0;
  logic       mosi_in = 1'b0;
  logic       miso_out;
  logic       icache_wen_out;
  logic       dcache_wen_out;
  logic [3:0] wr_addr_out;
  logic [7:0] wr_data_out;
  logic [3:0] rd_addr_out;
  logic [7:0] rd_data_in = 8'h00;
  logic       loading_out;
  logic       err_out;

  int checks = 0;
  int failures = 0;
  int ip = 0;
  int dp = 0;
  int ld_low = 0;

`ifdef SPI_LOADER_READBACK_EN
  localparam logic [7:0] RbExp = 8'h3C;
`else
  localparam logic [7:0] RbExp = 8'h00;
`endif

  spi_loader dut (
    .clk            (clk),
    .rst            (rst),
    .csi_in         (csi_in),
    .csd_in         (csd_in),
    .mosi_in        (mosi_in),
    .miso_out       (miso_out),
    .icache_wen_out (icache_wen_out),
    .dcache_wen_out (dcache_wen_out),
    .wr_addr_out    (wr_addr_out),
    .wr_data_out    (wr_data_out),
    .rd_addr_out    (rd_addr_out),
    .rd_data_in     (rd_data_in),
    .loading_out    (loading_out),
    .err_out        (err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ip += int'(icache_wen_out);
    dp += int'(dcache_wen_out);
    if (!loading_out) ld_low++;
  endtask

  task automatic clr();
    ip = 0;
    dp = 0;
    ld_low = 0;
  endtask

  // Send the first nbits of a 13-bit frame, select held for the whole span.
  task automatic send_bits(input logic si, input logic sd, input logic [12:0] frame,
                           input int nbits);
    csi_in = si;
    csd_in = sd;
    for (int i = 0; i < nbits; i++) begin
      mosi_in = frame[12-i];
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    csi_in = 1'b0;
    csd_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_icwen"}, 16'(icache_wen_out), 16'h0);
    check({tag, "_dcwen"}, 16'(dcache_wen_out), 16'h0);
    check({tag, "_wraddr"}, 16'(wr_addr_out), 16'h0);
    check({tag, "_wrdata"}, 16'(wr_data_out), 16'h0);
    check({tag, "_rdaddr"}, 16'(rd_addr_out), 16'h0);
    check({tag, "_miso"}, 16'(miso_out), 16'h0);
    check({tag, "_loading"}, 16'(loading_out), 16'h0);
    check({tag, "_err"}, 16'(err_out), 16'h0);
  endtask

  initial begin
    // Reset state
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // icache write 1_0011_10100101
    clr();
    send_bits(1'b1, 1'b0, 13'b1_0011_10100101, 13);
    check("ic_wen", 16'(icache_wen_out), 16'h1);
    check("ic_addr", 16'(wr_addr_out), 16'h3);
    check("ic_data", 16'(wr_data_out), 16'hA5);
    check("ic_dcwen", 16'(dp), 16'h0);
    check("ic_pulses", 16'(ip), 16'h1);
    check("ic_err", 16'(err_out), 16'h0);
    check("ic_load_strobe", 16'(loading_out), 16'h1);
    csi_in = 1'b0;
    tick();
    check("ic_wen_drop", 16'(icache_wen_out), 16'h0);
    check("ic_load_drop", 16'(loading_out), 16'h0);

    // Back-to-back dcache writes
    clr();
    send_bits(1'b0, 1'b1, 13'b1_0000_00010001, 13);
    check("b2b_first_wen", 16'(dcache_wen_out), 16'h1);
    check("b2b_first_addr", 16'(wr_addr_out), 16'h0);
    check("b2b_first_data", 16'(wr_data_out), 16'h11);
    send_bits(1'b0, 1'b1, 13'b1_1110_11111110, 13);
    check("b2b_pulses", 16'(dp), 16'h2);
    check("b2b_second_wen", 16'(dcache_wen_out), 16'h1);
    check("b2b_second_addr", 16'(wr_addr_out), 16'hE);
    check("b2b_second_data", 16'(wr_data_out), 16'hFE);
    check("b2b_ld_low", 16'(ld_low), 16'h0);
    csd_in = 1'b0;
    #1;
    check("b2b_load_strobe", 16'(loading_out), 16'h1);
    tick();
    check("b2b_load_drop", 16'(loading_out), 16'h0);
    check("b2b_err", 16'(err_out), 16'h0);

    // Illegal dcache address, then a legal one
    clr();
    send_bits(1'b0, 1'b1, 13'b1_1111_01110111, 13);
    check("ill_pulses", 16'(dp), 16'h0);
    check("ill_err", 16'(err_out), 16'h1);
    csd_in = 1'b0;
    tick();
    clr();
    send_bits(1'b0, 1'b1, 13'b1_0101_01011010, 13);
    check("ill_next_wen", 16'(dcache_wen_out), 16'h1);
    check("ill_next_addr", 16'(wr_addr_out), 16'h5);
    check("ill_next_data", 16'(wr_data_out), 16'h5A);
    check("ill_err_sticky", 16'(err_out), 16'h1);
    csd_in = 1'b0;
    tick();

    // Abort after 7 bits
    do_reset();
    check("abort_pre_err", 16'(err_out), 16'h0);
    clr();
    send_bits(1'b1, 1'b0, 13'b1_0110_11110000, 7);
    csi_in = 1'b0;
    tick();
    tick();
    check("abort_err", 16'(err_out), 16'h1);
    check("abort_pulses", 16'(ip), 16'h0);
    check("abort_idle", 16'(loading_out), 16'h0);
    clr();
    send_bits(1'b1, 1'b0, 13'b1_1001_11000011, 13);
    check("abort_next_wen", 16'(icache_wen_out), 16'h1);
    check("abort_next_addr", 16'(wr_addr_out), 16'h9);
    check("abort_next_data", 16'(wr_data_out), 16'hC3);
    csi_in = 1'b0;
    tick();

    // dcache read at addr 2, cache returns 0x3C
    do_reset();
    clr();
    rd_data_in = 8'h3C;
    csd_in = 1'b1;
    for (int i = 0; i < 13; i++) begin
      mosi_in = (i == 3) ? 1'b1 : 1'b0;  // frame 0_0010_00000000
      tick();
      if (i == 4) check("rb_rdaddr", 16'(rd_addr_out), 16'h2);
      if (i >= 4 && i <= 11) check($sformatf("rb_miso_cnt%0d", i + 1), 16'(miso_out),
                                   16'(RbExp[11-i]));
    end
    csd_in = 1'b0;
    tick();
    check("rb_no_strobe", 16'(dp), 16'h0);
    check("rb_err", 16'(err_out), 16'h0);

    // Reset at bit 8 of an icache write
    clr();
    send_bits(1'b1, 1'b0, 13'b1_0001_11111111, 8);
    rst = 1'b1;
    csi_in = 1'b0;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    tick();
    tick();
    check("midrst_pulses", 16'(ip), 16'h0);
    clr();
    send_bits(1'b1, 1'b0, 13'b1_0111_00111110, 13);
    check("midrst_next_wen", 16'(icache_wen_out), 16'h1);
    check("midrst_next_addr", 16'(wr_addr_out), 16'h7);
    check("midrst_next_data", 16'(wr_data_out), 16'h3E);
    csi_in = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
